// File: rtl/pwm_duty_ramp.sv
// Slew-rate limiter from the programmed target duty to the PWM duty input (RAMP_EXP_EN: exponential approach).
// Latency: 1 cycle in bypass (ramp_rate==0), ramp_rate cycles to the first step otherwise.
// Backpressure: none; hold freezes duty_out and the prescaler, busy/done stay live.
module pwm_duty_ramp #(
   parameter int DUTY_W = 8,
   parameter int RATE_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DUTY_W-1:0] target_duty,
   input  logic [RATE_W-1:0] ramp_rate,
   input  logic [3:0]        step_size,
   input  logic              hold,
   output logic [DUTY_W-1:0] duty_out,
   output logic              busy,
   output logic              done
);

   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [RATE_W-1:0] pcnt_q, pcnt_d;
   logic              was_busy_q, was_busy_d;

   logic [DUTY_W:0]   tgt_x;
   logic [DUTY_W:0]   cur_x;
   logic [DUTY_W:0]   delta;
   logic [DUTY_W:0]   step_s;
   logic [DUTY_W:0]   step_v;
   logic [DUTY_W:0]   next_x;
   logic              dir_up;
   logic              tick;

   assign busy     = (duty_q != target_duty);
   assign done     = was_busy_q & ~busy;
   assign duty_out = duty_q;

   // Step arithmetic is one bit wider than the duty so neither direction can wrap.
   always_comb begin
      tgt_x  = {1'b0, target_duty};
      cur_x  = {1'b0, duty_q};
      dir_up = (tgt_x > cur_x);
      delta  = dir_up ? (tgt_x - cur_x) : (cur_x - tgt_x);
      step_s = (step_size == 4'd0) ? {{DUTY_W{1'b0}}, 1'b1}
                                   : {{(DUTY_W - 3){1'b0}}, step_size};
`ifdef RAMP_EXP_EN
      step_v = ((delta >> 2) > step_s) ? (delta >> 2) : step_s;
`else
      step_v = step_s;
`endif
      // Landing exactly on target when the step would overshoot covers both clamps.
      if (step_v >= delta) begin
         next_x = tgt_x;
      end else if (dir_up) begin
         next_x = cur_x + step_v;
      end else begin
         next_x = cur_x - step_v;
      end
   end

   always_comb begin
      duty_d     = duty_q;
      pcnt_d     = pcnt_q;
      was_busy_d = busy;
      tick       = 1'b0;
      if (hold) begin
         duty_d = duty_q;
         pcnt_d = pcnt_q;
      end else if (ramp_rate == '0) begin
         duty_d = target_duty;
         pcnt_d = '0;
      end else if (!busy) begin
         pcnt_d = '0;
      end else begin
         // >= rather than == so a rate lowered mid-ramp still fires promptly.
         tick = (pcnt_q >= (ramp_rate - 1'b1));
         if (tick) begin
            pcnt_d = '0;
            duty_d = next_x[DUTY_W-1:0];
         end else begin
            pcnt_d = pcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         duty_q     <= '0;
         pcnt_q     <= '0;
         was_busy_q <= 1'b0;
      end else begin
         duty_q     <= duty_d;
         pcnt_q     <= pcnt_d;
         was_busy_q <= was_busy_d;
      end
   end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: bypass, linear ramps, clamps, redirect, hold, reset.
module tb_pwm_duty_ramp;

   logic       clk;
   logic       rst;
   logic [7:0] target_duty;
   logic [7:0] ramp_rate;
   logic [3:0] step_size;
   logic       hold;
   logic [7:0] duty_out;
   logic       busy;
   logic       done;

   int checks;
   int errors;
   int done_cnt;

   pwm_duty_ramp #(.DUTY_W(8), .RATE_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .target_duty(target_duty),
      .ramp_rate  (ramp_rate),
      .step_size  (step_size),
      .hold       (hold),
      .duty_out   (duty_out),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, got, exp);
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      target_duty = 8'd0;
      ramp_rate   = 8'd0;
      step_size   = 4'd0;
      hold        = 1'b0;

      // reset state
      edge1();
      chk("rst_duty", duty_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      target_duty = 8'd200;
      #1;
      chk("rst_busy_tgt", busy, 1);
      edge1();
      chk("rst_hold_duty", duty_out, 0);
      chk("rst_done2", done, 0);

      // bypass
      rst = 1'b0;
      edge1();
      chk("byp_duty", duty_out, 200);
      chk("byp_busy", busy, 0);
      chk("byp_done", done, 1);
      edge1();
      chk("byp_done_end", done, 0);

      // back to 0 through bypass, then linear up 0->10 at rate 4
      target_duty = 8'd0;
      edge1();
      edge1();
      chk("lin_start", duty_out, 0);
      target_duty = 8'd10;
      ramp_rate   = 8'd4;
      step_size   = 4'd1;
      done_cnt    = 0;
      for (int k = 1; k <= 40; k++) begin
         edge1();
         if (done) done_cnt++;
         if (k == 3) chk("lin_c3", duty_out, 0);
         if (k == 4) chk("lin_c4", duty_out, 1);
         if (k == 39) chk("lin_c39", duty_out, 9);
      end
      chk("lin_c40", duty_out, 10);
      chk("lin_done40", done, 1);
      chk("lin_done_cnt", done_cnt, 1);
      edge1();
      chk("lin_done41", done, 0);

      // clamp down 10->0, step 3, rate 1
      target_duty = 8'd0;
      ramp_rate   = 8'd1;
      step_size   = 4'd3;
      edge1();
      chk("dn_7", duty_out, 7);
      edge1();
      chk("dn_4", duty_out, 4);
      edge1();
      chk("dn_1", duty_out, 1);
      edge1();
      chk("dn_0", duty_out, 0);
      chk("dn_done", done, 1);
      edge1();
      chk("dn_stay0", duty_out, 0);

      // clamp up near max 250->255, step 15
      ramp_rate   = 8'd0;
      target_duty = 8'd250;
      edge1();
      chk("up_250", duty_out, 250);
      ramp_rate   = 8'd1;
      step_size   = 4'd15;
      target_duty = 8'd255;
      edge1();
      chk("up_255", duty_out, 255);
      edge1();
      chk("up_255_hold", duty_out, 255);

      // hold also freezes bypass
      ramp_rate   = 8'd0;
      hold        = 1'b1;
      target_duty = 8'd0;
      edge1();
      chk("hold_byp", duty_out, 255);
      chk("hold_byp_busy", busy, 1);
      hold = 1'b0;
      edge1();
      chk("byp_after_hold", duty_out, 0);
      edge1();

      // redirect: up-ramp at rate 2 reaches 5 at edge 10, then target 2
      ramp_rate   = 8'd2;
      step_size   = 4'd0;
      target_duty = 8'd10;
      for (int k = 1; k <= 10; k++) edge1();
      chk("rd_5", duty_out, 5);
      target_duty = 8'd2;
      edge1();
      chk("rd_wait", duty_out, 5);
      edge1();
      chk("rd_4", duty_out, 4);
      hold = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         edge1();
         if (k == 10) chk("hold_mid", duty_out, 4);
      end
      chk("hold_end", duty_out, 4);
      chk("hold_busy", busy, 1);
      hold = 1'b0;
      edge1();
      edge1();
      chk("rel_3", duty_out, 3);
      edge1();
      edge1();
      chk("rel_2", duty_out, 2);
      chk("rel_done", done, 1);
      edge1();
      chk("rel_done_end", done, 0);

      // reset mid-ramp at duty 6
      ramp_rate   = 8'd1;
      step_size   = 4'd1;
      target_duty = 8'd10;
      for (int k = 1; k <= 4; k++) edge1();
      chk("mr_6", duty_out, 6);
      rst = 1'b1;
      edge1();
      chk("mr_duty", duty_out, 0);
      chk("mr_done", done, 0);
      chk("mr_busy", busy, 1);

      // large jump: exponential first step when enabled, unit step otherwise
      rst         = 1'b0;
      target_duty = 8'd200;
      edge1();
`ifdef RAMP_EXP_EN
      chk("jump_first", duty_out, 50);
`else
      chk("jump_first", duty_out, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
